// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with write-before-read bypass and optional busy scoreboard (REGFILE_MP_SCOREBOARD_EN)
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_valid,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);
    logic [XLEN-1:0] regs   [NREGS];
    logic [XLEN-1:0] regs_n [NREGS];

    // storage after this cycle's writes; later ports overwrite earlier ones, r0 is never written
    always_comb begin
        regs_n = regs;
        for (int j = 0; j < NWR; j++)
            if (we[j] && wa[j*AW +: AW] != '0) regs_n[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
    end

    // commit storage and register read data from the bypassed view
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
            rd       <= '0;
            rd_valid <= '0;
        end else begin
            regs     <= regs_n;
            rd_valid <= rd_en;
            for (int i = 0; i < NRD; i++)
                if (rd_en[i]) rd[i*XLEN +: XLEN] <= regs_n[ra[i*AW +: AW]];
        end
    end

`ifdef REGFILE_MP_SCOREBOARD_EN
    logic [NREGS-1:0] busy, busy_n;

    // busy bits after writes clear and issue sets; set applied last so it wins
    always_comb begin
        busy_n = busy;
        for (int j = 0; j < NWR; j++)
            if (we[j]) busy_n[wa[j*AW +: AW]] = 1'b0;
        if (sb_set) busy_n[sb_addr] = 1'b1;
        busy_n[0] = 1'b0;
    end

    // commit busy bits and register read busy status from the updated view
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= '0;
            rd_busy <= '0;
        end else begin
            busy <= busy_n;
            for (int i = 0; i < NRD; i++)
                if (rd_en[i]) rd_busy[i] <= busy_n[ra[i*AW +: AW]];
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set, sb_addr};
    assign rd_busy   = '0;
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
`ifdef REGFILE_MP_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rd_en;
    logic [2*AW-1:0] ra;
    logic [63:0]   rd;
    logic [1:0]    rd_valid, rd_busy, we;
    logic [2*AW-1:0] wa;
    logic [63:0]   wd;
    logic          sb_set;
    logic [AW-1:0] sb_addr;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_reg  [NREGS];
    logic        m_busy [NREGS];
    logic [31:0] e_rd   [2];
    logic        e_busy [2];
    logic [1:0]  e_valid;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .ra(ra), .rd(rd),
        .rd_valid(rd_valid), .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rst, input logic [1:0] ren, input int a0, input int a1,
                         input logic [1:0] wen, input int w0, input int w1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit sbs, input int sba);
        reset = rst; rd_en = ren;
        ra = {a1[AW-1:0], a0[AW-1:0]};
        we = wen; wa = {w1[AW-1:0], w0[AW-1:0]};
        wd = {d1, d0};
        sb_set = sbs; sb_addr = sba[AW-1:0];
    endtask

    // predict the edge from the model, advance the clock, compare all outputs
    task automatic step();
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin m_reg[k] = '0; m_busy[k] = 1'b0; end
            e_valid = '0;
            for (int i = 0; i < 2; i++) begin e_rd[i] = '0; e_busy[i] = 1'b0; end
        end else begin
            e_valid = rd_en;
            for (int i = 0; i < 2; i++) begin
                if (rd_en[i]) begin
                    int a;
                    bit hit;
                    logic [31:0] v;
                    logic b;
                    a = int'(ra[i*AW +: AW]);
                    v = m_reg[a];
                    b = m_busy[a];
                    hit = 1'b0;
                    for (int j = 1; j >= 0; j--)
                        if (!hit && we[j] && int'(wa[j*AW +: AW]) == a) begin
                            v = wd[j*32 +: 32];
                            hit = 1'b1;
                        end
                    if (hit) b = 1'b0;
                    if (sb_set && int'(sb_addr) == a) b = 1'b1;
                    if (a == 0) begin v = '0; b = 1'b0; end
                    e_rd[i] = v;
                    e_busy[i] = b & SB;
                end
            end
            for (int j = 0; j < 2; j++)
                if (we[j]) begin
                    if (wa[j*AW +: AW] != 0) m_reg[wa[j*AW +: AW]] = wd[j*32 +: 32];
                    m_busy[wa[j*AW +: AW]] = 1'b0;
                end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 64'(rd_valid), 64'(e_valid));
        chk("rd0", 64'(rd[31:0]), 64'(e_rd[0]));
        chk("rd1", 64'(rd[63:32]), 64'(e_rd[1]));
        chk("rd_busy0", 64'(rd_busy[0]), 64'(e_busy[0]));
        chk("rd_busy1", 64'(rd_busy[1]), 64'(e_busy[1]));
    endtask

    initial begin
        drive(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        step();
        // read r5 and r0 straight after reset
        drive(0, 2'b11, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s1_rd", rd, 64'h0);
        chk("s1_valid", 64'(rd_valid), 64'h3);
        chk("s1_busy", 64'(rd_busy), 64'h0);
        // write r7 with same-cycle read, then read again
        drive(0, 2'b01, 7, 0, 2'b01, 7, 0, 32'hDEADBEEF, 0, 0, 0);
        step();
        chk("s2_bypass", 64'(rd[31:0]), 64'hDEADBEEF);
        drive(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 2'b10, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s2_stored", 64'(rd[63:32]), 64'hDEADBEEF);
        // colliding writes to r9: port 1 wins
        drive(0, 2'b01, 9, 0, 2'b11, 9, 9, 32'h1, 32'h2, 0, 0);
        step();
        chk("s3_bypass", 64'(rd[31:0]), 64'h2);
        drive(0, 2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s3_stored", 64'(rd[63:32]), 64'h2);
        // r0 ignores writes and never becomes busy
        drive(0, 2'b01, 0, 0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 1, 0);
        step();
        chk("s4_r0", 64'(rd[31:0]), 64'h0);
        chk("s4_r0busy", 64'(rd_busy[0]), 64'h0);
        // scoreboard set, set-beats-clear, then clear
        drive(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4);
        step();
        drive(0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s5_busy", 64'(rd_busy[0]), 64'(SB));
        drive(0, 2'b01, 4, 0, 2'b01, 4, 0, 32'h44, 0, 1, 4);
        step();
        chk("s5_setwins", 64'(rd_busy[0]), 64'(SB));
        chk("s5_data", 64'(rd[31:0]), 64'h44);
        drive(0, 2'b00, 0, 0, 2'b10, 0, 4, 0, 32'h45, 0, 0);
        step();
        drive(0, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s5_clear", 64'(rd_busy[0]), 64'h0);
        // write during reset is discarded
        drive(1, 2'b11, 3, 3, 2'b01, 3, 0, 32'h55, 0, 1, 3);
        step();
        chk("s6_valid", 64'(rd_valid), 64'h0);
        drive(0, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("s6_r3", 64'(rd[31:0]), 64'h0);
        chk("s6_valid_after", 64'(rd_valid), 64'h1);
        // randomized traffic concentrated on a few registers to force collisions
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 60) == 0), 2'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 2'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two >= 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- rd_en  in  NRD  per-port read enable
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NRD*XLEN  registered read data
- rd_valid  out  NRD  high one cycle after an enabled read
- rd_busy  out  NRD  registered scoreboard status of the address read
- we  in  NWR  per-port write enable
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- sb_set  in  1  mark register sb_addr busy (instruction issue)
- sb_addr  in  AW  scoreboard set address

Function
REQ-006 Read latency SHALL be one cycle: rd[i], rd_busy[i] update at the edge sampling rd_en[i]=1.
REQ-007 rd_valid[i] SHALL equal rd_en[i] delayed one cycle; with rd_en[i]=0, rd[i] and rd_busy[i] SHALL hold.
REQ-008 Address 0 SHALL read as 0; writes to address 0 SHALL be discarded; register 0 SHALL never be busy.
REQ-009 Write-before-read: a read matching any same-cycle enabled write SHALL return that write's wd, not old storage.
REQ-010 Multiple same-cycle writes to one address: highest-indexed write port SHALL win, for both storage and bypass.
REQ-011 Storage write SHALL take effect at the sampling edge; a read one cycle later returns the stored value.
REQ-012 Scoreboard: one busy bit per register, sampled-edge updated.
REQ-013 sb_set=1 SHALL set busy[sb_addr]; any enabled write to address a SHALL clear busy[a].
REQ-014 Same-cycle sb_set and write to the same address: set SHALL win (busy=1 afterward; data still written).
REQ-015 rd_busy[i] SHALL reflect busy[ra[i]] after that cycle's set/clear updates (bypassed like data).
REQ-016 NRD, NWR >= 1; all ports SHALL operate independently and concurrently.

Reset
REQ-017 reset=1 at a clock edge SHALL clear all storage, all busy bits, rd, rd_valid, rd_busy to 0.
REQ-018 reset SHALL take priority over writes, reads, and sb_set in the same cycle; those are discarded.
REQ-019 Reads issued the cycle after reset deasserts SHALL behave normally (rd_valid one cycle later).

Configuration
REQ-020 Macro REGFILE_MP_SCOREBOARD_EN: when defined, scoreboard per REQ-012..015 SHALL be built.
REQ-021 When undefined: no busy storage; rd_busy SHALL be constant 0; sb_set, sb_addr ignored; data path unchanged.

Verification
REQ-022 Scenarios (default parameters, macro defined):
- Reset, then read ra0=5, ra1=0 -> next cycle rd0=0, rd1=0, rd_valid=2'b11, rd_busy=0.
- Write wa0=7 wd0=0xDEADBEEF plus read ra0=7 same cycle -> next cycle rd0=0xDEADBEEF; read r7 again later -> 0xDEADBEEF.
- we=2'b11, wa0=wa1=9, wd0=0x1, wd1=0x2 -> r9 reads 0x2, both bypassed and stored.
- Write wa0=0 wd0=0xFFFFFFFF, read ra0=0 -> rd0=0; sb_set sb_addr=0 -> rd_busy stays 0.
- sb_set sb_addr=4; next cycle read r4 -> rd_busy=1; write r4 with sb_set sb_addr=4 same cycle -> busy stays 1; write r4 alone -> read busy 0.
- Write r3=0x55 and reset same cycle -> r3 reads 0, rd_valid=0 during reset cycle; macro undefined -> rd_busy always 0.
